// File: rtl/memstream_cfg_arbiter.sv
// memstream_cfg_arbiter: sole master of a memstream config port, interleaving a sequential
// weight-load stream with single host reads/writes; host read data returns through a 2-entry FIFO.
module memstream_cfg_arbiter #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int BURST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_vld,
    output logic             ld_rdy,
    input  logic [WIDTH-1:0] ld_dat,
    output logic             ld_done,
    input  logic             hst_req,
    input  logic             hst_we,
    input  logic [31:0]      hst_addr,
    input  logic [WIDTH-1:0] hst_wdat,
    output logic             hst_ack,
    output logic             hst_rvld,
    input  logic             hst_rrdy,
    output logic [WIDTH-1:0] hst_rdat,
    output logic             cfg_ce,
    output logic             cfg_we,
    output logic [31:0]      cfg_address,
    output logic [WIDTH-1:0] cfg_d0,
    input  logic             cfg_rack,
    input  logic [WIDTH-1:0] cfg_q0
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOST} state_t;

    state_t           state, nxt;
    logic [1:0]       rs;
    logic             arst_n;
    logic [AW-1:0]    ptr;
    logic [BW-1:0]    bcnt;
    logic             last_ld;
    logic [1:0]       rinf;
    logic [2:0]       oob;
    logic [1:0]       fcnt;
    logic             hd, tl;
    logic [WIDTH-1:0] fmem [2];
    logic [2:0]       used;
    logic             credit, hst_oob, last_wr;
    logic             ld_fire, issue_h, rd_real, rd_oob;
    logic             take, push, pop;
    logic [WIDTH-1:0] pdat;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rs <= '0;
        else rs <= {rs[0], 1'b1};
    assign arst_n = rs[1];

    // Reads in flight plus buffered responses never exceed the FIFO depth.
    assign used    = 3'(fcnt) + 3'(rinf) + 3'(oob[0]) + 3'(oob[1]) + 3'(oob[2]);
    assign credit  = used < 3'd2;
    assign hst_oob = hst_addr >= 32'(DEPTH);
    assign last_wr = ptr == AW'(DEPTH - 1);

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = hst_req && (last_ld || !ld_vld) ? HOST : ld_vld ? LOAD : IDLE;
            LOAD:    nxt = !ld_vld || bcnt == BW'(BURST - 1) || last_wr ? IDLE : LOAD;
            HOST:    nxt = hst_ack || !hst_req ? IDLE : HOST;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_rdy  = state == LOAD;
        ld_fire = ld_rdy && ld_vld;
        hst_ack = state == HOST && hst_req && (hst_we || credit);
        issue_h = hst_ack && !hst_oob;
        rd_real = issue_h && !hst_we;
        rd_oob  = hst_ack && hst_oob && !hst_we;
    end

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            cfg_ce      <= 1'b0;
            cfg_we      <= 1'b0;
            cfg_address <= '0;
            cfg_d0      <= '0;
            ld_done     <= 1'b0;
            ptr         <= '0;
            bcnt        <= '0;
            last_ld     <= 1'b0;
        end else begin
            cfg_ce  <= ld_fire || issue_h;
            cfg_we  <= ld_fire || (issue_h && hst_we);
            ld_done <= ld_fire && last_wr;
            if (ld_fire || issue_h) begin
                cfg_address <= ld_fire ? 32'(ptr) : hst_addr;
                cfg_d0      <= ld_fire ? ld_dat : hst_wdat;
            end
            if (ld_fire) ptr <= last_wr ? '0 : ptr + AW'(1);
            bcnt    <= state == LOAD ? bcnt + BW'(ld_fire) : '0;
            last_ld <= state == IDLE && nxt != IDLE ? nxt == LOAD : last_ld;
        end

    // Out-of-range reads ride a delay line matching the rack latency so responses stay ordered.
    assign take = cfg_rack && rinf != 2'd0;
    assign push = take || oob[2];
    assign pdat = take ? cfg_q0 : '0;
    assign pop  = hst_rvld && hst_rrdy;

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            rinf    <= '0;
            oob     <= '0;
            fcnt    <= '0;
            hd      <= 1'b0;
            tl      <= 1'b0;
            fmem[0] <= '0;
            fmem[1] <= '0;
        end else begin
            rinf <= rinf + 2'(rd_real) - 2'(take);
            oob  <= {oob[1:0], rd_oob};
            fcnt <= fcnt + 2'(push) - 2'(pop);
            if (push) begin
                fmem[tl] <= pdat;
                tl       <= ~tl;
            end
            if (pop) hd <= ~hd;
        end

    assign hst_rvld = fcnt != 2'd0;
    assign hst_rdat = fmem[hd];
endmodule

// File: tb/tb_memstream_cfg_arbiter.sv
// tb_memstream_cfg_arbiter: directed scoreboard bench; expected cfg accesses and read responses
// are queued at each handshake and popped by a monitor against a small memstream model.
module tb_memstream_cfg_arbiter;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int BURST = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        done;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n, ld_vld, ld_rdy, ld_done, hst_req, hst_we, hst_ack, hst_rvld, hst_rrdy;
    logic [31:0] ld_dat, hst_addr, hst_wdat, hst_rdat, cfg_address, cfg_d0, cfg_q0;
    logic        cfg_ce, cfg_we, cfg_rack, stray;

    acc_t        cq[$];
    logic [31:0] rq[$];
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] mem [DEPTH];
    int          exp_ptr = 0;
    int          ld_hs = 0;
    int          checks = 0;
    int          errors = 0;

    logic        r1, r2;
    logic [31:0] a1, q2;

    always #5 clk = ~clk;

    memstream_cfg_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_dat(ld_dat), .ld_done(ld_done),
        .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdat(hst_wdat),
        .hst_ack(hst_ack), .hst_rvld(hst_rvld), .hst_rrdy(hst_rrdy), .hst_rdat(hst_rdat),
        .cfg_ce(cfg_ce), .cfg_we(cfg_we), .cfg_address(cfg_address), .cfg_d0(cfg_d0),
        .cfg_rack(cfg_rack), .cfg_q0(cfg_q0)
    );

    // memstream model: rack exactly two cycles after a read cycle
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (cfg_ce && cfg_we) mem[cfg_address[2:0]] <= cfg_d0;
        r1 <= cfg_ce && !cfg_we;
        a1 <= cfg_address;
        r2 <= r1;
        q2 <= mem[a1[2:0]];
    end
    assign cfg_rack = r2 | stray;
    assign cfg_q0   = q2;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_ce) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg_unexpected: got addr %h we %b expected no access", cfg_address, cfg_we);
                end else begin
                    acc_t e;
                    e = cq.pop_front();
                    check("cfg_we", cfg_we, e.we);
                    check("cfg_addr", cfg_address, e.a);
                    if (e.we) check("cfg_d0", cfg_d0, e.d);
                    check("ld_done", ld_done, e.done);
                end
            end else if (ld_done) begin
                checks++;
                errors++;
                $display("FAIL ld_done_stray: got 1 expected 0");
            end
            if (hst_rvld && hst_rrdy) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %h expected none", hst_rdat);
                end else check("rsp_data", hst_rdat, rq.pop_front());
            end
        end
    end

    task automatic ld_word(input logic [31:0] d, output int waited);
        ld_vld = 1'b1;
        ld_dat = d;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ld_rdy && waited < 50);
        if (!ld_rdy) begin
            checks++;
            errors++;
            $display("FAIL ld_timeout: got no ld_rdy expected handshake within 50 cycles");
        end else begin
            cq.push_back(acc_t'{we: 1'b1, a: 32'(exp_ptr), d: d, done: exp_ptr == DEPTH - 1});
            exp_mem[exp_ptr] = d;
            exp_ptr = (exp_ptr + 1) % DEPTH;
            ld_hs++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic host(input logic we, input logic [31:0] a, input logic [31:0] d, input int max,
                        output logic acked, output int waited);
        hst_req  = 1'b1;
        hst_we   = we;
        hst_addr = a;
        hst_wdat = d;
        waited   = 0;
        acked    = 1'b0;
        while (!acked && waited < max) begin
            @(negedge clk);
            waited++;
            acked = hst_ack;
        end
        if (acked) begin
            if (a < DEPTH) begin
                cq.push_back(acc_t'{we: we, a: a, d: d, done: 1'b0});
                if (we) exp_mem[a] = d;
            end
            if (!we) rq.push_back(a < DEPTH ? exp_mem[a] : 32'h0);
            @(posedge clk);
            #1;
            hst_req = 1'b0;
        end
    endtask

    task automatic rst_outputs(input string n);
        check({n, "_flags"}, 32'({ld_rdy, ld_done, hst_ack, hst_rvld, cfg_ce, cfg_we}), 32'h0);
        check({n, "_addr"}, cfg_address, 32'h0);
        check({n, "_d0"}, cfg_d0, 32'h0);
        check({n, "_rdat"}, hst_rdat, 32'h0);
    endtask

    int   w, tot, wl, hw, nld, base;
    logic ack, ack3;

    initial begin
        rst_n = 1'b0; ld_vld = 1'b0; ld_dat = '0; hst_req = 1'b0; hst_we = 1'b0;
        hst_addr = '0; hst_wdat = '0; hst_rrdy = 1'b1; stray = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 9 load words: addresses 0..7 then wrap to 0; two bursts of 4 plus two bubbles
        tot = 0;
        for (int i = 0; i < 9; i++) begin
            ld_word(32'hA0 + i, w);
            if (i < 8) tot += w;
        end
        ld_vld = 1'b0;
        check("ld_cycles8", tot, 10);
        repeat (4) @(posedge clk);
        #1;

        // host write then read back
        host(1'b1, 3, 32'h55, 20, ack, w);
        check("wr_ack", ack, 1);
        host(1'b0, 3, 0, 20, ack, w);
        check("rd_ack", ack, 1);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!cfg_rack && w < 10);
        check("rack_seen", cfg_rack, 1);
        @(negedge clk);
        check("rvld_after_rack", hst_rvld, 1);
        check("rdat_after_rack", hst_rdat, 32'h55);
        repeat (3) @(posedge clk);
        #1;

        // load and host contend
        base = ld_hs;
        fork
            begin
                for (int i = 0; i < 8; i++) ld_word(32'hB0 + i, wl);
                ld_vld = 1'b0;
            end
            begin
                host(1'b1, 6, 32'h77, 20, ack3, hw);
                nld = ld_hs - base;
            end
        join
        check("t3_ack", ack3, 1);
        check("t3_loads_before_host", nld, BURST);
        check("t3_latency_ok", 32'(hw <= BURST + 3), 1);
        repeat (6) @(posedge clk);
        #1;

        // response back-pressure: third read waits for FIFO credit
        hst_rrdy = 1'b0;
        host(1'b0, 1, 0, 20, ack, w);
        check("rd1_ack", ack, 1);
        host(1'b0, 2, 0, 20, ack, w);
        check("rd2_ack", ack, 1);
        host(1'b0, 5, 0, 10, ack, w);
        check("rd3_blocked", ack, 0);
        check("fifo_full_rvld", hst_rvld, 1);
        hst_rrdy = 1'b1;
        host(1'b0, 5, 0, 20, ack, w);
        check("rd3_ack", ack, 1);
        repeat (8) @(posedge clk);
        #1;
        check("rsp_drained", rq.size(), 0);

        // out-of-range host accesses
        host(1'b0, DEPTH + 2, 0, 20, ack, w);
        check("oob_rd_ack", ack, 1);
        host(1'b1, DEPTH, 32'hDEAD, 20, ack, w);
        check("oob_wr_ack", ack, 1);
        repeat (8) @(posedge clk);
        #1;
        check("oob_rsp_drained", rq.size(), 0);

        // reset inside a burst starting at ptr 5
        for (int i = 0; i < 4; i++) ld_word(32'hC1 + i, w);
        ld_dat = 32'hC5;
        @(negedge clk);
        @(negedge clk);
        check("burst2_rdy", ld_rdy, 1);
        #1 rst_n = 1'b0;
        #1 rst_outputs("midrst");
        exp_ptr = 0;
        ld_vld  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stray_ignored", hst_rvld, 0);
        ld_word(32'hD0, w);
        ld_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("cfg_drained", cq.size(), 0);
        check("rsp_final", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected end within 200000 time units");
        $fatal(1);
    end
endmodule
